// File: rtl/vds_pkg.sv
// Shared definitions for the virtual 1-Wire EEPROM memory-function responders:
// command codes, CRC16 constant, FSM encodings and the byte-wise CRC16 step.
package vds_pkg;

    localparam logic [7:0]  CMD_WRITE_SP = 8'h0F;
    localparam logic [7:0]  CMD_READ_SP  = 8'hAA;
    localparam logic [7:0]  CMD_COPY_SP  = 8'h55;
    localparam logic [7:0]  CMD_READ_MEM = 8'hF0;

    // x16 + x15 + x2 + 1, bit-reversed for LSB-first shifting
    localparam logic [15:0] CRC16_POLY   = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_TA1,
        ST_HDR_TA2,
        ST_HDR_ES,
        ST_DATA,
        ST_CRC_L,
        ST_CRC_H,
        ST_FILL
    } rd_state_t;

    typedef enum logic [1:0] {
        PH_TRIG,
        PH_FALL,
        PH_RISE
    } xfer_phase_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/vds_crc16_acc.sv
// CRC16 accumulator with clear / seed / update controls; crc_upd previews the
// value after folding the current data byte so callers can use it same-cycle.
module vds_crc16_acc
    import vds_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        clear,
    input  logic        seed,
    input  logic [7:0]  seed_val,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [15:0] crc,
    output logic [15:0] crc_upd
);

    logic [15:0] crc_reg;

    assign crc_upd = crc16_byte(crc_reg, data);
    assign crc     = crc_reg;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crc_reg <= '0;
        end else if (clear) begin
            crc_reg <= '0;
        end else if (seed) begin
            crc_reg <= crc16_byte(16'h0000, seed_val);
        end else if (update) begin
            crc_reg <= crc_upd;
        end
    end

endmodule

// File: rtl/virtual_ds_mem_read_scratchpad_p.sv
// Read Scratchpad responder: streams TA1/TA2/ES, scratchpad bytes from the
// target offset, the inverted CRC16, then fill bytes until the bus is reset.
module virtual_ds_mem_read_scratchpad_p
    import vds_pkg::*;
#(
    parameter int         SP_BYTES  = 8,
    parameter logic [7:0] CMD_CODE  = 8'hAA,
    parameter bit         CRC_EN    = 1'b1,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [SP_BYTES*8-1:0] Scratchpad,
    input  logic [7:0]            TA1,
    input  logic [7:0]            TA2,
    input  logic [7:0]            ES,
    input  logic                  cmdRunTrig,
    input  logic                  cmdAbort,
    input  logic                  ByteTransDone,
    output logic [7:0]            sentDat,
    output logic                  transTrig,
    output logic                  nRxTx,
    output logic                  cmdBusy,
    output logic                  cmdDone
);

    localparam int             AW       = $clog2(SP_BYTES);
    localparam int             LAST     = SP_BYTES - 1;
    localparam logic [AW:0]    LAST_IDX = LAST[AW:0];
    localparam logic [AW:0]    CNT_ONE  = {{AW{1'b0}}, 1'b1};

    rd_state_t   state_reg, state_next;
    xfer_phase_t phase_reg, phase_next;
    logic [AW:0] cnt_reg, cnt_next;
    logic [7:0]  sent_dat_reg, sent_dat_next;
    logic        trans_trig_reg, trans_trig_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        trig_d_reg;
    logic [AW-1:0] off_reg;
    logic [7:0]  ta2_reg, es_reg;
    logic [7:0]  sp_reg [SP_BYTES];

    logic        run_rise, latch_en, byte_done;
    logic        crc_clear, crc_seed, crc_update;
    logic [15:0] crc_val, crc_upd;
    logic [AW:0] cnt_inc;

    assign run_rise = cmdRunTrig & ~trig_d_reg;
    assign cnt_inc  = cnt_reg + CNT_ONE;

    for (genvar gi = 0; gi < SP_BYTES; gi++) begin : g_sp
        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                sp_reg[gi] <= '0;
            end else if (latch_en) begin
                sp_reg[gi] <= Scratchpad[8*gi +: 8];
            end
        end
    end

    vds_crc16_acc u_crc (
        .clk      (clk),
        .nRst     (nRst),
        .clear    (crc_clear),
        .seed     (crc_seed),
        .seed_val (CMD_CODE),
        .update   (crc_update),
        .data     (sent_dat_reg),
        .crc      (crc_val),
        .crc_upd  (crc_upd)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= PH_TRIG;
            cnt_reg        <= '0;
            sent_dat_reg   <= '0;
            trans_trig_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            trig_d_reg     <= 1'b0;
            off_reg        <= '0;
            ta2_reg        <= '0;
            es_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            cnt_reg        <= cnt_next;
            sent_dat_reg   <= sent_dat_next;
            trans_trig_reg <= trans_trig_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            trig_d_reg     <= cmdRunTrig;
            if (latch_en) begin
                off_reg <= TA1[AW-1:0];
                ta2_reg <= TA2;
                es_reg  <= ES;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        cnt_next        = cnt_reg;
        sent_dat_next   = sent_dat_reg;
        trans_trig_next = 1'b0;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        latch_en        = 1'b0;
        byte_done       = 1'b0;
        crc_clear       = 1'b0;
        crc_seed        = 1'b0;
        crc_update      = 1'b0;

        if (state_reg == ST_IDLE) begin
            if (run_rise) begin
                latch_en      = 1'b1;
                crc_seed      = 1'b1;
                state_next    = ST_HDR_TA1;
                phase_next    = PH_TRIG;
                sent_dat_next = TA1;
                busy_next     = 1'b1;
            end
        end else if (cmdAbort) begin
            state_next = ST_IDLE;
            phase_next = PH_TRIG;
            busy_next  = 1'b0;
            crc_clear  = 1'b1;
        end else begin
            case (phase_reg)
                PH_TRIG: begin
                    trans_trig_next = 1'b1;
                    phase_next      = PH_FALL;
                end
                PH_FALL: if (!ByteTransDone) phase_next = PH_RISE;
                PH_RISE: if (ByteTransDone) begin
                    byte_done  = 1'b1;
                    phase_next = PH_TRIG;
                end
                default: phase_next = PH_TRIG;
            endcase

            // Load the next byte on the same edge the current one completes
            if (byte_done) begin
                case (state_reg)
                    ST_HDR_TA1: begin
                        crc_update    = 1'b1;
                        state_next    = ST_HDR_TA2;
                        sent_dat_next = ta2_reg;
                    end
                    ST_HDR_TA2: begin
                        crc_update    = 1'b1;
                        state_next    = ST_HDR_ES;
                        sent_dat_next = es_reg;
                    end
                    ST_HDR_ES: begin
                        crc_update    = 1'b1;
                        state_next    = ST_DATA;
                        cnt_next      = {1'b0, off_reg};
                        sent_dat_next = sp_reg[off_reg];
                    end
                    ST_DATA: begin
                        crc_update = 1'b1;
                        if (cnt_reg == LAST_IDX) begin
                            if (CRC_EN) begin
                                state_next    = ST_CRC_L;
                                sent_dat_next = ~crc_upd[7:0];
                            end else begin
                                state_next    = ST_FILL;
                                sent_dat_next = FILL_BYTE;
                                done_next     = 1'b1;
                            end
                        end else begin
                            cnt_next      = cnt_inc;
                            sent_dat_next = sp_reg[cnt_inc[AW-1:0]];
                        end
                    end
                    ST_CRC_L: begin
                        state_next    = ST_CRC_H;
                        sent_dat_next = ~crc_val[15:8];
                    end
                    ST_CRC_H: begin
                        state_next    = ST_FILL;
                        sent_dat_next = FILL_BYTE;
                        done_next     = 1'b1;
                    end
                    default: sent_dat_next = FILL_BYTE;
                endcase
            end
        end
    end

    assign sentDat   = sent_dat_reg;
    assign transTrig = trans_trig_reg;
    assign nRxTx     = busy_reg;
    assign cmdBusy   = busy_reg;
    assign cmdDone   = done_reg;

endmodule
